// File: rtl/mc_core_ws.sv
// Multicycle MIPS-subset core: control FSM and datapath sharing one req/ready memory port.
// Stalls on wait states, halts on an illegal instruction or a bus timeout.
module mc_core_ws #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  err_code
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [WAIT_W:0] MAX_WAIT_C = (WAIT_W + 1)'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  logic              run_q, run_d;
  logic [31:0][31:0] rf_q, rf_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, jump_target, rs_val, rt_val;
  logic        funct_legal;
  logic        mem_done, mem_stall, timeout;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  function automatic logic [31:0] alu_result(input logic [5:0]  f,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    logic [31:0] r;
    case (f)
      FN_SUB:  r = x - y;
      FN_AND:  r = x & y;
      FN_OR:   r = x | y;
      FN_SLT:  r = {31'd0, $signed(x) < $signed(y)};
      default: r = x + y;
    endcase
    return r;
  endfunction

  assign opcode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign funct       = ir_q[5:0];
  assign simm        = {{16{ir_q[15]}}, ir_q[15:0]};
  // pc_q already holds PC+4 once the instruction has been fetched
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign rs_val      = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val      = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign funct_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                       (funct == FN_OR)  || (funct == FN_SLT);

  assign mem_done  = mem_req && mem_ready;
  assign mem_stall = mem_req && !mem_ready;
  assign timeout   = (MAX_WAIT != 0) && mem_stall &&
                     (({1'b0, wait_q} + 1'b1) == MAX_WAIT_C);

  assign pc       = pc_q;
  assign halted   = (state_q == S_HALT);
  assign err_code = err_q;

  // run_q keeps the first request off until one edge after reset is released
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    case (state_q)
      S_FETCH: mem_req = run_q;
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = alu_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    err_d    = err_q;
    run_d    = 1'b1;
    wait_d   = mem_stall ? wait_q + 1'b1 : '0;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;

    case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        alu_d = pc_q + (simm << 2);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal) begin
              state_d = S_EXEC;
            end else begin
              state_d = S_HALT;
              err_d   = ERR_ILLEGAL;
            end
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_d   = a_q + simm;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_done) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_done) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_d   = alu_result(funct, a_q, b_q);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) begin
          pc_d = alu_q;
        end
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + simm;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = jump_target;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase

    // A timed-out access never completed, so nothing above was updated by it
    if (timeout) begin
      state_d = S_HALT;
      err_d   = ERR_TIMEOUT;
    end

    rf_d = rf_q;
    if (rf_we && (rf_waddr != 5'd0)) begin
      rf_d[rf_waddr] = rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
      run_q   <= 1'b0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      run_q   <= run_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_mc_core_ws.sv
// Self-checking bench for mc_core_ws: a table of instructions run from a behavioural
// memory, then hand-written sequences for wait states, timeout, illegal opcodes and reset.
module tb_mc_core_ws;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        halted;
  logic [1:0]  err_code;

  mc_core_ws #(
    .RESET_PC(32'h0000_0100),
    .MAX_WAIT(4),
    .WAIT_W  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .halted   (halted),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: 256 words, loader port used by the stimulus, DUT writes logged
  logic [31:0] mem [0:255];
  logic        ld_en, ld_clear;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  int          wr_count;
  logic [31:0] last_waddr, last_wdata;

  initial begin
    wr_count   = 0;
    last_waddr = '0;
    last_wdata = '0;
  end

  always @(posedge clk) begin
    if (ld_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_count   <= wr_count + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[9:2]];

  // Accesses to slow_addr are held off for wait_n cycles
  logic [31:0] slow_addr;
  int          wait_n;
  int          acc_cyc;

  assign mem_ready = !(mem_req && (mem_addr == slow_addr) && (acc_cyc < wait_n));

  always @(posedge clk or negedge reset) begin
    if (!reset)                     acc_cyc <= 0;
    else if (mem_req && !mem_ready) acc_cyc <= acc_cyc + 1;
    else                            acc_cyc <= 0;
  end

  int errors;
  int checks;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          cycles;
    logic [31:0] next_pc;
    bit          is_store;
    logic [31:0] w_addr;
    logic [31:0] w_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] ins, input int cyc,
                         input logic [31:0] npc, input bit st,
                         input logic [31:0] wa, input logic [31:0] wd);
    vec_t v;
    v.addr = a; v.instr = ins; v.cycles = cyc; v.next_pc = npc;
    v.is_store = st; v.w_addr = wa; v.w_data = wd;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    ld_addr = byte_addr[9:2];
    ld_data = data;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] slow, input int waits);
    reset     = 1'b0;
    slow_addr = slow;
    wait_n    = waits;
    ld_clear  = 1'b1;
    @(negedge clk);
    ld_clear  = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    #1;
    check_output("no req before first edge", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("first fetch req/we", {30'd0, mem_req, mem_we}, 32'h2);
    check_output("first fetch addr", mem_addr, 32'h100);
  endtask

  // Program starting at the reset vector; expected results are worked out by hand
  task automatic build_vectors();
    add_vec(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5),      4, 32'h104, 0, 0, 0);
    add_vec(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),   4, 32'h108, 0, 0, 0);
    add_vec(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20),       4, 32'h10C, 0, 0, 0);
    add_vec(32'h10C, enc_r(5'd2, 5'd1, 5'd4, 6'h22),       4, 32'h110, 0, 0, 0);
    add_vec(32'h110, enc_r(5'd2, 5'd1, 5'd5, 6'h2A),       4, 32'h114, 0, 0, 0);
    add_vec(32'h114, enc_r(5'd1, 5'd2, 5'd6, 6'h2A),       4, 32'h118, 0, 0, 0);
    add_vec(32'h118, enc_r(5'd1, 5'd2, 5'd7, 6'h24),       4, 32'h11C, 0, 0, 0);
    add_vec(32'h11C, enc_r(5'd1, 5'd2, 5'd8, 6'h25),       4, 32'h120, 0, 0, 0);
    add_vec(32'h120, enc_i(6'h2B, 5'd0, 5'd3, 16'd0),      4, 32'h124, 1, 32'h00, 32'h0000_0002);
    add_vec(32'h124, enc_i(6'h2B, 5'd0, 5'd4, 16'd36),     4, 32'h128, 1, 32'h24, 32'hFFFF_FFF8);
    add_vec(32'h128, enc_i(6'h2B, 5'd0, 5'd5, 16'd8),      4, 32'h12C, 1, 32'h08, 32'h0000_0001);
    add_vec(32'h12C, enc_i(6'h2B, 5'd0, 5'd6, 16'd12),     4, 32'h130, 1, 32'h0C, 32'h0000_0000);
    add_vec(32'h130, enc_i(6'h2B, 5'd0, 5'd7, 16'd16),     4, 32'h134, 1, 32'h10, 32'h0000_0005);
    add_vec(32'h134, enc_i(6'h2B, 5'd0, 5'd8, 16'd20),     4, 32'h138, 1, 32'h14, 32'hFFFF_FFFD);
    add_vec(32'h138, enc_i(6'h23, 5'd0, 5'd9, 16'h40),     5, 32'h13C, 0, 0, 0);
    add_vec(32'h13C, enc_i(6'h2B, 5'd0, 5'd9, 16'd24),     4, 32'h140, 1, 32'h18, 32'hDEAD_BEEF);
    add_vec(32'h140, enc_i(6'h08, 5'd0, 5'd11, 16'h48),    4, 32'h144, 0, 0, 0);
    add_vec(32'h144, enc_i(6'h23, 5'd11, 5'd10, 16'hFFF8), 5, 32'h148, 0, 0, 0);
    add_vec(32'h148, enc_r(5'd10, 5'd1, 5'd12, 6'h20),     4, 32'h14C, 0, 0, 0);
    add_vec(32'h14C, enc_i(6'h2B, 5'd0, 5'd12, 16'd32),    4, 32'h150, 1, 32'h20, 32'hDEAD_BEF4);
    add_vec(32'h150, enc_i(6'h08, 5'd0, 5'd0, 16'd7),      4, 32'h154, 0, 0, 0);
    add_vec(32'h154, enc_i(6'h2B, 5'd0, 5'd0, 16'd28),     4, 32'h158, 1, 32'h1C, 32'h0000_0000);
    add_vec(32'h158, enc_i(6'h04, 5'd1, 5'd2, 16'd3),      3, 32'h15C, 0, 0, 0);
    add_vec(32'h15C, enc_i(6'h04, 5'd1, 5'd1, 16'd2),      3, 32'h168, 0, 0, 0);
    add_vec(32'h168, enc_j(26'h5E),                        3, 32'h178, 0, 0, 0);
    add_vec(32'h178, enc_i(6'h2B, 5'd0, 5'd1, 16'd4),      4, 32'h17C, 1, 32'h04, 32'h0000_0005);
    add_vec(32'h17C, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),   3, 32'h17C, 0, 0, 0);
    add_vec(32'h17C, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),   3, 32'h17C, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_before;
    int req_seen;

    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    ld_en     = 1'b0;
    ld_clear  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    slow_addr = 32'hFFFF_FFFF;
    wait_n    = 0;
    build_vectors();
    #1;

    // ---------------- Table-driven program, zero wait states ----------------
    do_reset(32'hFFFF_FFFF, 0);
    for (int i = 0; i < vecs.size(); i++) poke(vecs[i].addr, vecs[i].instr);
    poke(32'h40, 32'hDEAD_BEEF);
    check_output("reset mem_req", {31'd0, mem_req}, 32'd0);
    check_output("reset pc", pc, 32'h100);
    check_output("reset halted", {31'd0, halted}, 32'd0);
    check_output("reset err_code", {30'd0, err_code}, 32'd0);
    release_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      wr_before = wr_count;
      step(vecs[i].cycles);
      check_output($sformatf("vec%0d fetch req/we", i), {30'd0, mem_req, mem_we}, 32'h2);
      check_output($sformatf("vec%0d fetch addr", i), mem_addr, vecs[i].next_pc);
      check_output($sformatf("vec%0d pc", i), pc, vecs[i].next_pc);
      check_output($sformatf("vec%0d write count", i), wr_count - wr_before,
                   vecs[i].is_store ? 32'd1 : 32'd0);
      if (vecs[i].is_store) begin
        check_output($sformatf("vec%0d store addr", i), last_waddr, vecs[i].w_addr);
        check_output($sformatf("vec%0d store data", i), last_wdata, vecs[i].w_data);
      end
    end
    check_output("program halted", {31'd0, halted}, 32'd0);

    // ---------------- lw with three wait states ----------------
    do_reset(32'h40, 3);
    poke(32'h100, enc_i(6'h23, 5'd0, 5'd2, 16'h40));
    poke(32'h104, enc_i(6'h2B, 5'd0, 5'd2, 16'h44));
    poke(32'h108, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    poke(32'h40, 32'hDEAD_BEEF);
    release_reset();
    step(3);
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("lw stall%0d req/we", k), {30'd0, mem_req, mem_we}, 32'h2);
      check_output($sformatf("lw stall%0d addr", k), mem_addr, 32'h40);
      check_output($sformatf("lw stall%0d ready", k), {31'd0, mem_ready}, 32'd0);
      step(1);
    end
    check_output("lw complete addr", mem_addr, 32'h40);
    step(2);
    check_output("lw next fetch addr", mem_addr, 32'h104);
    check_output("lw next pc", pc, 32'h104);
    wr_before = wr_count;
    step(4);
    check_output("lw result write count", wr_count - wr_before, 32'd1);
    check_output("lw result store addr", last_waddr, 32'h44);
    check_output("lw result store data", last_wdata, 32'hDEAD_BEEF);

    // ---------------- Illegal opcode 0x3F reached by a jump ----------------
    do_reset(32'hFFFF_FFFF, 0);
    poke(32'h100, enc_j(26'd2));
    poke(32'h008, 32'hFC00_0000);
    release_reset();
    step(3);
    check_output("illegal fetch addr", mem_addr, 32'h8);
    check_output("illegal halted early", {31'd0, halted}, 32'd0);
    step(2);
    check_output("illegal halted", {31'd0, halted}, 32'd1);
    check_output("illegal err_code", {30'd0, err_code}, 32'd1);
    check_output("illegal pc", pc, 32'hC);
    req_seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (mem_req) req_seen++;
      step(1);
    end
    check_output("halt req quiet cycles", req_seen, 32'd0);
    check_output("halt sticky", {29'd0, halted, err_code}, 32'h5);

    // ---------------- Unlisted R-type funct ----------------
    do_reset(32'hFFFF_FFFF, 0);
    poke(32'h100, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
    release_reset();
    step(2);
    check_output("bad funct halted", {31'd0, halted}, 32'd1);
    check_output("bad funct err_code", {30'd0, err_code}, 32'd1);
    check_output("bad funct req", {31'd0, mem_req}, 32'd0);

    // ---------------- Fetch timeout with MAX_WAIT=4 ----------------
    do_reset(32'h100, 1000);
    release_reset();
    step(3);
    check_output("timeout 4th stall halted", {31'd0, halted}, 32'd0);
    check_output("timeout 4th stall req", {31'd0, mem_req}, 32'd1);
    step(1);
    check_output("timeout halted", {31'd0, halted}, 32'd1);
    check_output("timeout err_code", {30'd0, err_code}, 32'd2);
    check_output("timeout req", {31'd0, mem_req}, 32'd0);
    check_output("timeout pc", pc, 32'h100);

    // ---------------- Ready arriving on the last allowed cycle ----------------
    do_reset(32'h100, 3);
    poke(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'h4C));
    poke(32'h108, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    release_reset();
    step(3);
    check_output("late ready halted", {31'd0, halted}, 32'd0);
    step(1);
    check_output("late ready pc", pc, 32'h104);
    check_output("late ready halted after", {31'd0, halted}, 32'd0);
    step(3);
    check_output("late ready next fetch", mem_addr, 32'h104);
    wr_before = wr_count;
    step(4);
    check_output("late ready store data", last_wdata, 32'h5);
    check_output("late ready store count", wr_count - wr_before, 32'd1);
    check_output("late ready err_code", {30'd0, err_code}, 32'd0);

    // ---------------- Reset during a stalled store ----------------
    do_reset(32'h48, 1000);
    poke(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'h48));
    poke(32'h048, 32'hA5A5_A5A5);
    release_reset();
    step(4);
    check_output("mid-reset sw fetch", mem_addr, 32'h104);
    step(3);
    check_output("stalled sw req/we", {30'd0, mem_req, mem_we}, 32'h3);
    check_output("stalled sw addr", mem_addr, 32'h48);
    check_output("stalled sw wdata", mem_wdata, 32'h5);
    step(2);
    check_output("stalled sw held addr", mem_addr, 32'h48);
    check_output("stalled sw held req/we", {30'd0, mem_req, mem_we}, 32'h3);
    wr_before = wr_count;
    #2;
    reset = 1'b0;
    #1;
    check_output("async reset drops req", {31'd0, mem_req}, 32'd0);
    check_output("async reset pc", pc, 32'h100);
    @(negedge clk);
    slow_addr = 32'hFFFF_FFFF;
    check_output("aborted sw write count", wr_count - wr_before, 32'd0);
    check_output("aborted sw memory", mem[8'h12], 32'hA5A5_A5A5);
    release_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_core_ws.md
Name: mc_core_ws

Overview:
- Parametrised multicycle MIPS-subset core: datapath and main control FSM in one block.
- Single unified memory port with a req/ready wait-state handshake, so slow or shared memories stall the core cleanly.
- Adds a configurable reset vector, a bus-timeout error, and halt-on-illegal-opcode.
- Sits between the top level and the unified instruction/data memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, maximum stall cycles per memory access; 0 disables the timeout.
- WAIT_W, 5, width of the stall counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  byte address; valid while mem_req=1.
- mem_wdata  out  32  store data; valid while mem_req & mem_we.
- mem_rdata  in  32  read data; sampled when mem_req & mem_ready & !mem_we.
- mem_ready  in  1  access completes in any cycle where mem_req & mem_ready.
- pc  out  32  current PC register.
- halted  out  1  sticky; core stopped.
- err_code  out  2  00 none, 01 illegal opcode, 10 bus timeout; sticky.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC; state = FETCH; mem_req = 0; halted = 0; err_code = 00.
  - IR, MDR, A, B, ALUOut and all 32 registers cleared.
  - mem_req may assert no earlier than the first rising edge after reset deasserts.
  - Reset asserted mid-access aborts the access immediately; no register or PC update from the aborted access.
- Register file:
  - 32 x 32 bits, two combinational read ports, one synchronous write port.
  - $0 always reads 0; writes to $0 are discarded.
- Supported opcodes: R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
  - Any other opcode, or an unlisted R-type funct, is illegal.
- ALU and immediates:
  - 32-bit wrap-around add/sub; slt is a signed compare.
  - Immediates are sign-extended.
  - Branch target = PC+4 + (simm << 2).
  - Jump target = {PC+4[31:28], instr[25:0], 2'b00}.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR <= mem_rdata, pc <= pc+4 -> DECODE.
  - DECODE: A <= rs, B <= rt, ALUOut <= pc + (simm << 2).
    - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP; illegal -> HALT with err 01.
  - MEMADR: ALUOut <= A + simm. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: mem_req=1, addr=ALUOut. On ready: MDR <= mem_rdata -> MEMWB.
  - MEMWB: rt <= MDR -> FETCH.
  - MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. On ready -> FETCH.
  - EXEC: ALUOut <= A op B -> ALUWB.
  - ALUWB: rd <= ALUOut -> FETCH.
  - BRANCH: if A==B then pc <= ALUOut. -> FETCH.
  - ADDIEX: ALUOut <= A + simm -> ADDIWB.
  - ADDIWB: rt <= ALUOut -> FETCH.
  - JUMP: pc <= jump target -> FETCH.
  - HALT: terminal; halted=1, mem_req=0; exited only by reset.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Handshake:
  - While mem_req=1 and mem_ready=0, state, mem_addr, mem_we and mem_wdata hold stable.
  - mem_req deasserts the cycle after the completing ready, except when FETCH is entered directly from MEMWR. In that case req stays high and the address changes to pc.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - A wait counter clears on every new access and increments each stalled cycle.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT with ready still low: go to HALT, err 10, access abandoned, no state update.
  - Ready arriving in the same cycle the counter reaches MAX_WAIT counts as success.
- Unaligned addresses are not checked; mem_addr[1:0] is passed through unchanged.
- PC wraps modulo 2^32.

Test Plan:
- Reset with RESET_PC=32'h100, memory ready always 1 -> first mem_addr=0x100; after `addi $1,$0,5` (0x20010005), reg1 = 5 and pc = 0x104 after 4 cycles.
- lw with 3 wait cycles: mem[0x40]=0xDEADBEEF, `lw $2,0x40($0)` -> completes in 8 cycles; addr/we held stable during waits; reg2 = 0xDEADBEEF.
- `sw $1,4($0)` with reg1=5 -> one write cycle with mem_we=1, addr=0x4, wdata=5; `beq $1,$1,-1` -> pc returns to the branch's own address.
- Opcode 0x3F fetched at pc=0x8 -> HALT; halted=1, err_code=01, mem_req stays 0 for 100 cycles.
- MAX_WAIT=4, ready held low on fetch -> halted after 4 stall cycles, err_code=10. Repeat with ready arriving on exactly the 4th stall cycle -> normal completion.
- reset pulsed low mid-MEMWR stall -> mem_req drops asynchronously; memory is not written; fetch restarts at RESET_PC.
